// File: rtl/patch_stream_reader_if.sv
// Pixel stream bundle between the patch reader and its consumers.
// The master drives the beat and its coordinates. The slave returns ready.
interface patch_stream_reader_if #(
  parameter int PW = 16,
  parameter int PH = 16,
  parameter int DW = 10
);
  localparam int XW = (PW > 1) ? $clog2(PW) : 1;
  localparam int YW = (PH > 1) ? $clog2(PH) : 1;

  logic          o_valid;
  logic          i_ready;
  logic          o_last;
  logic [DW-1:0] o_R;
  logic [DW-1:0] o_G;
  logic [DW-1:0] o_B;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;

  modport master (
    output o_valid, o_last, o_R, o_G, o_B, o_x, o_y,
    input  i_ready
  );

  modport slave (
    input  o_valid, o_last, o_R, o_G, o_B, o_x, o_y,
    output i_ready
  );
endinterface

// File: rtl/patch_stream_reader.sv
// Streams a stored PWxPH RGB patch in raster order, one pixel per accepted beat.
// Each beat is captured from i_buf when it is loaded and then holds until it is accepted.
module patch_stream_reader #(
  parameter int PW = 16,
  parameter int PH = 16,
  parameter int DW = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [3*PH*PW*DW-1:0]  i_buf,
  output logic                   o_busy,
  output logic                   o_done,
  patch_stream_reader_if.master  strm
);

  localparam int XW = (PW > 1) ? $clog2(PW) : 1;
  localparam int YW = (PH > 1) ? $clog2(PH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t        state_q;
  logic          valid_q;
  logic          last_q;
  logic          busy_q;
  logic          done_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [DW-1:0] r_q;
  logic [DW-1:0] g_q;
  logic [DW-1:0] b_q;

  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;
  logic [DW-1:0] r_d;
  logic [DW-1:0] g_d;
  logic [DW-1:0] b_d;
  logic          last_d;

  function automatic logic [DW-1:0] fetch_px(
    input logic [3*PH*PW*DW-1:0] buf_v,
    input int                    chan,
    input logic [XW-1:0]         px,
    input logic [YW-1:0]         py
  );
    fetch_px = buf_v[((chan*PH + int'(py))*PW + int'(px))*DW +: DW];
  endfunction

  // Coordinates and pixel of the beat that would be loaded next: (0,0) from IDLE, else raster successor.
  always_comb begin
    x_d = '0;
    y_d = '0;
    if (state_q == ST_IDLE) begin
      x_d = '0;
      y_d = '0;
    end else if (x_q == XW'(PW-1)) begin
      x_d = '0;
      y_d = y_q + YW'(1);
    end else begin
      x_d = x_q + XW'(1);
      y_d = y_q;
    end
    r_d    = fetch_px(i_buf, 0, x_d, y_d);
    g_d    = fetch_px(i_buf, 1, x_d, y_d);
    b_d    = fetch_px(i_buf, 2, x_d, y_d);
    last_d = (x_d == XW'(PW-1)) && (y_d == YW'(PH-1));
  end

  // Readout FSM. All outputs are registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (i_start) begin
            state_q <= ST_STREAM;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            last_q  <= last_d;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        ST_STREAM: begin
          // Abort takes priority over a transfer that completes at the same edge.
          if (i_abort) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (valid_q && strm.i_ready) begin
            if (last_q) begin
              state_q <= ST_DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              x_q    <= x_d;
              y_q    <= y_d;
              r_q    <= r_d;
              g_q    <= g_d;
              b_q    <= b_d;
              last_q <= last_d;
            end
          end else begin
            state_q <= ST_STREAM;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign strm.o_valid = valid_q;
  assign strm.o_last  = last_q;
  assign strm.o_x     = x_q;
  assign strm.o_y     = y_q;
  assign strm.o_R     = r_q;
  assign strm.o_G     = g_q;
  assign strm.o_B     = b_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule
